// File: rtl/ecc_scrub_ctrl.sv
// Background SEC scrubber sharing one memory port with a host; host wins except during CHK/WB/NEXT.
// Scrub reads issue from RD; corrected words are written back in WB; error counters saturate at 0xFFFF.
module ecc_scrub_ctrl #(
  parameter int ADDR_W         = 8,
  parameter int DEPTH          = 256,
  parameter int SCRUB_INTERVAL = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scrub_en,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [31:0]       host_wdata,
  input  logic [5:0]        host_wparity,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [31:0]       host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [5:0]        mem_wparity,
  input  logic [31:0]       mem_rdata,
  input  logic [5:0]        mem_rparity,
  output logic [31:0]       sec_data,
  output logic [5:0]        sec_parity,
  input  logic [31:0]       sec_corrected_data,
  input  logic [5:0]        sec_corrected_parity,
  input  logic [5:0]        sec_error_location,
  output logic              scrub_busy,
  output logic              pass_done,
  output logic [15:0]       corr_count,
  output logic [15:0]       uncorr_count,
  output logic [ADDR_W-1:0] last_err_addr
);

  localparam int CNT_W = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [CNT_W-1:0]  IVL_LAST  = CNT_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [5:0]        SYN_CORR_MAX = 6'd38;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  ivl_q, ivl_d;
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
  logic [31:0]       wb_data_q, wb_data_d;
  logic [5:0]        wb_par_q, wb_par_d;
  logic [15:0]       corr_cnt_q, corr_cnt_d;
  logic [15:0]       uncorr_cnt_q, uncorr_cnt_d;
  logic [ADDR_W-1:0] last_err_q, last_err_d;
  logic              rvalid_q, rvalid_d;
  logic              host_window;

  assign sec_data      = mem_rdata;
  assign sec_parity    = mem_rparity;
  assign scrub_busy    = (state_q != S_IDLE);
  assign pass_done     = (state_q == S_NEXT) && (scrub_addr_q == ADDR_LAST);
  assign corr_count    = corr_cnt_q;
  assign uncorr_count  = uncorr_cnt_q;
  assign last_err_addr = last_err_q;
  assign host_rvalid   = rvalid_q;
  assign host_rdata    = rvalid_q ? sec_corrected_data : 32'd0;

  // Host is locked out from CHK through NEXT so it can never race a writeback.
  assign host_window = (state_q == S_IDLE) || (state_q == S_WAIT) || (state_q == S_RD);
  assign host_gnt    = host_req && host_window && !reset;
  assign rvalid_d    = host_gnt && !host_we;

  always_comb begin
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'd0;
    mem_wparity = 6'd0;
    if (reset) begin
      mem_en = 1'b0;
    end else if (host_gnt) begin
      mem_en      = 1'b1;
      mem_we      = host_we;
      mem_addr    = host_addr;
      mem_wdata   = host_we ? host_wdata : 32'd0;
      mem_wparity = host_we ? host_wparity : 6'd0;
    end else if (state_q == S_RD) begin
      mem_en   = 1'b1;
      mem_addr = scrub_addr_q;
    end else if (state_q == S_WB) begin
      mem_en      = 1'b1;
      mem_we      = 1'b1;
      mem_addr    = scrub_addr_q;
      mem_wdata   = wb_data_q;
      mem_wparity = wb_par_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    ivl_d        = ivl_q;
    scrub_addr_d = scrub_addr_q;
    wb_data_d    = wb_data_q;
    wb_par_d     = wb_par_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    last_err_d   = last_err_q;
    case (state_q)
      S_IDLE: begin
        if (scrub_en) begin
          state_d = S_WAIT;
          ivl_d   = '0;
        end
      end
      S_WAIT: begin
        if (ivl_q == IVL_LAST) begin
          state_d = S_RD;
        end else begin
          ivl_d = ivl_q + CNT_W'(1);
        end
      end
      S_RD: begin
        if (!host_req) begin
          state_d = S_CHK;
        end
      end
      S_CHK: begin
        wb_data_d = sec_corrected_data;
        wb_par_d  = sec_corrected_parity;
        if (sec_error_location == 6'd0) begin
          state_d = S_NEXT;
        end else if (sec_error_location <= SYN_CORR_MAX) begin
          corr_cnt_d = (corr_cnt_q == 16'hFFFF) ? corr_cnt_q : corr_cnt_q + 16'd1;
          last_err_d = scrub_addr_q;
          state_d    = S_WB;
        end else begin
          uncorr_cnt_d = (uncorr_cnt_q == 16'hFFFF) ? uncorr_cnt_q : uncorr_cnt_q + 16'd1;
          last_err_d   = scrub_addr_q;
          state_d      = S_NEXT;
        end
      end
      S_WB: begin
        state_d = S_NEXT;
      end
      S_NEXT: begin
        scrub_addr_d = (scrub_addr_q == ADDR_LAST) ? '0 : scrub_addr_q + ADDR_W'(1);
        if (scrub_en) begin
          state_d = S_WAIT;
          ivl_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ivl_q        <= '0;
      scrub_addr_q <= '0;
      wb_data_q    <= 32'd0;
      wb_par_q     <= 6'd0;
      corr_cnt_q   <= 16'd0;
      uncorr_cnt_q <= 16'd0;
      last_err_q   <= '0;
      rvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ivl_q        <= ivl_d;
      scrub_addr_q <= scrub_addr_d;
      wb_data_q    <= wb_data_d;
      wb_par_q     <= wb_par_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
      last_err_q   <= last_err_d;
      rvalid_q     <= rvalid_d;
    end
  end

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Bench for ecc_scrub_ctrl: memory + SEC model, expected accesses queued and compared as they appear.
module tb_ecc_scrub_ctrl;

  localparam int AW    = 8;
  localparam int DEPTH = 4;
  localparam int IVL   = 4;

  logic          clk = 1'b0;
  logic          reset, scrub_en, host_req, host_we;
  logic [AW-1:0] host_addr;
  logic [31:0]   host_wdata;
  logic [5:0]    host_wparity;
  logic          host_gnt, host_rvalid;
  logic [31:0]   host_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata, sec_data, sec_corrected_data;
  logic [5:0]    mem_wparity, mem_rparity, sec_parity, sec_corrected_parity, sec_error_location;
  logic          scrub_busy, pass_done;
  logic [15:0]   corr_count, uncorr_count;
  logic [AW-1:0] last_err_addr;

  ecc_scrub_ctrl #(.ADDR_W(AW), .DEPTH(DEPTH), .SCRUB_INTERVAL(IVL)) dut (
    .clk(clk), .reset(reset), .scrub_en(scrub_en),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_wparity(host_wparity),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wparity(mem_wparity),
    .mem_rdata(mem_rdata), .mem_rparity(mem_rparity),
    .sec_data(sec_data), .sec_parity(sec_parity),
    .sec_corrected_data(sec_corrected_data), .sec_corrected_parity(sec_corrected_parity),
    .sec_error_location(sec_error_location),
    .scrub_busy(scrub_busy), .pass_done(pass_done),
    .corr_count(corr_count), .uncorr_count(uncorr_count), .last_err_addr(last_err_addr)
  );

  always #5 clk = ~clk;

  // Memory and SEC model: a word differing from its golden value reports syn_tab, corrected = golden.
  logic [37:0] golden  [256];
  logic [37:0] image   [256];
  logic [5:0]  syn_tab [256];
  logic [37:0] mem     [256];
  logic [7:0]  rd_addr_q = 8'd0;
  logic        load_req = 1'b0;
  logic [37:0] rd_word;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) mem[i] <= image[i];
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= {mem_wparity, mem_wdata};
      else        rd_addr_q <= mem_addr;
    end
  end

  assign mem_rdata            = mem[rd_addr_q][31:0];
  assign mem_rparity          = mem[rd_addr_q][37:32];
  assign rd_word              = {sec_parity, sec_data};
  assign sec_error_location   = (rd_word == golden[rd_addr_q]) ? 6'd0 : syn_tab[rd_addr_q];
  assign sec_corrected_data   = golden[rd_addr_q][31:0];
  assign sec_corrected_parity = golden[rd_addr_q][37:32];

  logic [123:0] outs;
  assign outs = {host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata,
                 mem_wparity, scrub_busy, pass_done, corr_count, uncorr_count, last_err_addr};

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [37:0] wd;
    int          gap;
  } acc_t;

  int test_cnt = 0;
  int fail_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mem();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic clean_image();
    for (int i = 0; i < 256; i++) begin
      image[i]   = golden[i];
      syn_tab[i] = 6'd0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; scrub_en = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = 32'd0; host_wparity = 6'd0;
    repeat (2) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; host_req = 1'b1; scrub_en = 1'b1; host_addr = 8'h33;
    step(); #1;
    test_cnt++;
    if (outs !== 124'd0) begin
      fail_cnt++; $display("FAIL reset_outputs: got %h exp 0", outs);
    end
    do_reset();
  endtask

  task automatic test_scrub_pass(input string name, input int bad, input logic [5:0] syn, input int nwords);
    acc_t        e;
    acc_t        exp_q[$];
    int          prev, cyc, last_cyc, pd_cnt, wraps, a, bound;
    logic        fixed;
    logic [15:0] exp_corr, exp_unc;
    logic [7:0]  exp_last;
    logic [46:0] got, want;
    clean_image();
    if (bad >= 0) begin
      image[bad]   = golden[bad] ^ 38'h20;
      syn_tab[bad] = syn;
    end
    load_mem();
    do_reset();
    prev = 0; fixed = 1'b0; exp_corr = 16'd0; exp_unc = 16'd0; exp_last = 8'd0; wraps = 0;
    for (int i = 0; i < nwords; i++) begin
      a = i % DEPTH;
      e.we = 1'b0; e.addr = 8'(a); e.wd = 38'd0;
      e.gap = (prev == 0) ? 0 : ((prev == 1) ? IVL + 3 : IVL + 2);
      exp_q.push_back(e);
      prev = 1;
      if (a == bad && !fixed && syn != 6'd0) begin
        exp_last = 8'(a);
        if (syn <= 6'd38) begin
          fixed = 1'b1; exp_corr++;
          e.we = 1'b1; e.wd = golden[a]; e.gap = 2;
          exp_q.push_back(e);
          prev = 2;
        end else begin
          exp_unc++;
        end
      end
      if (i < nwords - 1 && a == DEPTH - 1) wraps++;
    end
    scrub_en = 1'b1;
    cyc = 0; last_cyc = 0; pd_cnt = 0; bound = nwords * (IVL + 6) + 20;
    while (exp_q.size() != 0 && cyc < bound) begin
      #1;
      if (pass_done === 1'b1) pd_cnt++;
      if (mem_en === 1'b1) begin
        e    = exp_q.pop_front();
        got  = {mem_we, mem_addr, (mem_we === 1'b1) ? {mem_wparity, mem_wdata} : 38'd0};
        want = {e.we, e.addr, e.wd};
        test_cnt++;
        if (got !== want) begin
          fail_cnt++; $display("FAIL %s_access: got %h exp %h", name, got, want);
        end
        if (e.gap != 0) begin
          test_cnt++;
          if (cyc - last_cyc != e.gap) begin
            fail_cnt++; $display("FAIL %s_gap: got %0d exp %0d", name, cyc - last_cyc, e.gap);
          end
        end
        last_cyc = cyc;
      end
      step();
      cyc++;
    end
    test_cnt++;
    if (exp_q.size() != 0) begin
      fail_cnt++; $display("FAIL %s_timeout: got %0d pending exp 0", name, exp_q.size());
    end
    repeat (3) step();
    #1;
    test_cnt++;
    if (pd_cnt != wraps) begin
      fail_cnt++; $display("FAIL %s_pass_done: got %0d exp %0d", name, pd_cnt, wraps);
    end
    test_cnt++;
    if ({corr_count, uncorr_count, last_err_addr} !== {exp_corr, exp_unc, exp_last}) begin
      fail_cnt++;
      $display("FAIL %s_status: got %h/%h/%h exp %h/%h/%h", name,
               corr_count, uncorr_count, last_err_addr, exp_corr, exp_unc, exp_last);
    end
    if (bad >= 0) begin
      test_cnt++;
      want = {9'd0, fixed ? golden[bad] : image[bad]};
      if (mem[bad] !== want[37:0]) begin
        fail_cnt++; $display("FAIL %s_mem_word: got %h exp %h", name, mem[bad], want[37:0]);
      end
    end
    scrub_en = 1'b0;
  endtask

  task automatic test_host_hold();
    logic [31:0] hq[$];
    logic [31:0] e;
    clean_image();
    load_mem();
    do_reset();
    scrub_en = 1'b1; host_req = 1'b1; host_we = 1'b0;
    for (int i = 0; i < 12; i++) begin
      host_addr = 8'(16 + i);
      #1;
      test_cnt++;
      if (!(host_gnt === 1'b1 && mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === host_addr)) begin
        fail_cnt++;
        $display("FAIL host_hold_grant: got gnt=%b en=%b we=%b addr=%h exp 1/1/0/%h",
                 host_gnt, mem_en, mem_we, mem_addr, host_addr);
      end
      if (host_rvalid === 1'b1 && hq.size() != 0) begin
        e = hq.pop_front();
        test_cnt++;
        if (host_rdata !== e) begin
          fail_cnt++; $display("FAIL host_hold_rdata: got %h exp %h", host_rdata, e);
        end
      end
      if (host_gnt === 1'b1) hq.push_back(golden[host_addr][31:0]);
      step();
    end
    host_req = 1'b0;
    #1;
    test_cnt++;
    if (!(mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 8'd0 && host_gnt === 1'b0)) begin
      fail_cnt++;
      $display("FAIL host_release_scrub_rd: got en=%b we=%b addr=%h gnt=%b exp 1/0/00/0",
               mem_en, mem_we, mem_addr, host_gnt);
    end
    if (host_rvalid === 1'b1 && hq.size() != 0) begin
      e = hq.pop_front();
      test_cnt++;
      if (host_rdata !== e) begin
        fail_cnt++; $display("FAIL host_hold_last_rdata: got %h exp %h", host_rdata, e);
      end
    end
    step(); #1;
    test_cnt++;
    if (hq.size() != 0 || host_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      fail_cnt++;
      $display("FAIL host_hold_drain: got pending=%0d rvalid=%b en=%b exp 0/0/0", hq.size(), host_rvalid, mem_en);
    end
    scrub_en = 1'b0;
  endtask

  task automatic test_host_in_chk();
    logic [31:0] hq[$];
    logic [31:0] e;
    int          cyc;
    clean_image();
    image[0] = golden[0] ^ 38'h20;          syn_tab[0] = 6'd6;
    image[5] = golden[5] ^ 38'h20_0000_0000; syn_tab[5] = 6'd38;
    load_mem();
    do_reset();
    scrub_en = 1'b1;
    cyc = 0;
    #1;
    while (!(mem_en === 1'b1 && mem_we === 1'b0) && cyc < 20) begin
      step(); #1; cyc++;
    end
    test_cnt++;
    if (cyc >= 20) begin
      fail_cnt++; $display("FAIL chk_find_rd: got %0d cycles exp <20", cyc);
    end
    step();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'd5;
    #1;
    test_cnt++;
    if (host_gnt !== 1'b0) begin
      fail_cnt++; $display("FAIL chk_gnt_in_chk: got %b exp 0", host_gnt);
    end
    step(); #1;
    test_cnt++;
    if (!(host_gnt === 1'b0 && mem_we === 1'b1 && mem_addr === 8'd0 && {mem_wparity, mem_wdata} === golden[0])) begin
      fail_cnt++;
      $display("FAIL chk_gnt_in_wb: got gnt=%b we=%b addr=%h wd=%h exp 0/1/00/%h",
               host_gnt, mem_we, mem_addr, {mem_wparity, mem_wdata}, golden[0]);
    end
    step(); #1;
    test_cnt++;
    if (!(host_gnt === 1'b0 && mem_en === 1'b0)) begin
      fail_cnt++; $display("FAIL chk_gnt_in_next: got gnt=%b en=%b exp 0/0", host_gnt, mem_en);
    end
    step(); #1;
    test_cnt++;
    if (!(host_gnt === 1'b1 && mem_en === 1'b1 && mem_we === 1'b0 && mem_addr === 8'd5)) begin
      fail_cnt++;
      $display("FAIL chk_gnt_in_wait: got gnt=%b en=%b we=%b addr=%h exp 1/1/0/05",
               host_gnt, mem_en, mem_we, mem_addr);
    end
    if (host_gnt === 1'b1) hq.push_back(golden[5][31:0]);
    step();
    host_req = 1'b0;
    #1;
    test_cnt++;
    if (host_rvalid !== 1'b1 || hq.size() == 0) begin
      fail_cnt++; $display("FAIL chk_rvalid: got %b exp 1", host_rvalid);
    end else begin
      e = hq.pop_front();
      test_cnt++;
      if (host_rdata !== e) begin
        fail_cnt++; $display("FAIL chk_rdata: got %h exp %h", host_rdata, e);
      end
    end
    repeat (2) step();
    #1;
    test_cnt++;
    if ({corr_count, uncorr_count, last_err_addr} !== {16'd1, 16'd0, 8'd0}) begin
      fail_cnt++;
      $display("FAIL chk_counts: got %h/%h/%h exp 0001/0000/00", corr_count, uncorr_count, last_err_addr);
    end
    scrub_en = 1'b0;
  endtask

  task automatic test_saturation_reset();
    logic [15:0] exp_corr;
    logic        wb3;
    int          cyc;
    clean_image();
    image[0] = golden[0] ^ 38'h20;  syn_tab[0] = 6'd6;
    image[1] = golden[1] ^ 38'h20;  syn_tab[1] = 6'd6;
    image[2] = golden[2] ^ 38'h200; syn_tab[2] = 6'd45;
    image[3] = golden[3] ^ 38'h20;  syn_tab[3] = 6'd6;
    load_mem();
    do_reset();
    dut.corr_cnt_q   = 16'hFFFE;
    dut.uncorr_cnt_q = 16'hFFFF;
    exp_corr = 16'hFFFE;
    for (int i = 0; i < 3; i++) exp_corr = (exp_corr == 16'hFFFF) ? exp_corr : exp_corr + 16'd1;
    scrub_en = 1'b1;
    wb3 = 1'b0; cyc = 0;
    while (!wb3 && cyc < 100) begin
      #1;
      if (mem_en === 1'b1 && mem_we === 1'b1 && mem_addr === 8'd3) wb3 = 1'b1;
      else begin
        step(); cyc++;
      end
    end
    test_cnt++;
    if (!wb3) begin
      fail_cnt++; $display("FAIL sat_find_wb: got %0d cycles exp <100", cyc);
    end
    test_cnt++;
    if ({corr_count, uncorr_count, last_err_addr} !== {exp_corr, 16'hFFFF, 8'd3}) begin
      fail_cnt++;
      $display("FAIL sat_counts: got %h/%h/%h exp %h/ffff/03", corr_count, uncorr_count, last_err_addr, exp_corr);
    end
    reset = 1'b1;
    #1;
    test_cnt++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
      fail_cnt++; $display("FAIL rst_in_wb_port: got en=%b we=%b exp 0/0", mem_en, mem_we);
    end
    step(); #1;
    test_cnt++;
    if (outs !== 124'd0) begin
      fail_cnt++; $display("FAIL rst_in_wb_outputs: got %h exp 0", outs);
    end
    test_cnt++;
    if (mem[3] !== image[3]) begin
      fail_cnt++; $display("FAIL rst_in_wb_no_write: got %h exp %h", mem[3], image[3]);
    end
    do_reset();
  endtask

  initial begin
    reset = 1'b1; scrub_en = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = 32'd0; host_wparity = 6'd0;
    for (int i = 0; i < 256; i++) begin
      golden[i]  = {6'($urandom), 32'($urandom)};
      image[i]   = golden[i];
      syn_tab[i] = 6'd0;
    end
    load_mem();
    test_reset();
    test_scrub_pass("clean", -1, 6'd0, 5);
    test_scrub_pass("corr", 2, 6'd6, 7);
    test_scrub_pass("uncorr", 1, 6'd45, 6);
    test_host_hold();
    test_host_in_chk();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ecc_scrub_ctrl.md
Name: ecc_scrub_ctrl

Overview:
- Memory scrubber and port arbiter for the 32-bit data + 6-bit parity SEC-protected memory.
- Shares a single memory port between the host requester and a background scrub engine; host has priority.
- The scrub engine walks all addresses, checks each word through the external SEC corrector, and writes back corrected data/parity.
- Maintains error counters and status for software.

Parameters:
- ADDR_W, 8, memory address width.
- DEPTH, 256, number of words scrubbed; addresses 0..DEPTH-1.
- SCRUB_INTERVAL, 1024, idle cycles between consecutive scrub words (≥1).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- scrub_en  in  1  enable background scrubbing
- host_req  in  1  host access request; held until granted
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_W  host address
- host_wdata  in  32  host write data
- host_wparity  in  6  host write parity
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  host read data valid
- host_rdata  out  32  corrected host read data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  32  memory write data
- mem_wparity  out  6  memory write parity
- mem_rdata  in  32  read data, valid 1 cycle after read strobe
- mem_rparity  in  6  read parity, same timing
- sec_data  out  32  to SEC corrector; equals mem_rdata
- sec_parity  out  6  to SEC corrector; equals mem_rparity
- sec_corrected_data  in  32  from SEC corrector
- sec_corrected_parity  in  6  from SEC corrector
- sec_error_location  in  6  SEC syndrome
- scrub_busy  out  1  FSM not in IDLE
- pass_done  out  1  1-cycle pulse when scrub_addr wraps
- corr_count  out  16  corrected words; saturates at 0xFFFF
- uncorr_count  out  16  uncorrectable words; saturates at 0xFFFF
- last_err_addr  out  ADDR_W  address of most recent nonzero syndrome

Behaviour:
- Reset: FSM in IDLE. All outputs, scrub_addr, interval counter and both counters at 0.
- States and transitions:
  - IDLE: if scrub_en, go to WAIT and clear the interval counter.
  - WAIT: interval counter increments each cycle. At SCRUB_INTERVAL-1, go to RD.
  - RD: if host_req, host is served and FSM stays in RD. Otherwise issue read at scrub_addr (mem_en=1, mem_we=0) and go to CHK.
  - CHK: SEC outputs are valid this cycle.
    - Syndrome 0: go to NEXT.
    - Syndrome 1..38: corr_count++, record last_err_addr, go to WB.
    - Syndrome 39..63: uncorr_count++, record last_err_addr, no writeback, go to NEXT.
  - WB: write sec_corrected_data/sec_corrected_parity (registered in CHK) to scrub_addr, then go to NEXT.
  - NEXT: scrub_addr increments; DEPTH-1 wraps to 0 and asserts pass_done. Go to WAIT if scrub_en, else IDLE.
- Host arbitration:
  - host_gnt = host_req in IDLE, WAIT and RD; 0 in CHK, WB and NEXT. This blocks host writes from racing a writeback.
  - Granted access drives the memory port that same cycle with host fields.
  - A granted read produces host_rvalid=1 the next cycle with host_rdata = sec_corrected_data. Host reads are never written back or counted.
  - A host write drives host_wdata/host_wparity directly.
- Datapath and ordering:
  - SEC is combinational. The memory port issues at most one access per cycle, so host and scrub read data never overlap.
  - Worst-case host stall is 3 cycles (CHK, WB, NEXT).
- scrub_en deasserted mid-word: the current word completes through NEXT, then IDLE. scrub_addr is retained and the next pass resumes there.
- Counters hold at 0xFFFF and are cleared only by reset.
- Reset mid-operation (e.g. in WB) aborts immediately with no memory write that cycle.

Test Plan:
- Clean memory, SCRUB_INTERVAL=4, DEPTH=4, scrub_en=1, syndrome 0 → one read every 7 cycles; no writes; pass_done pulses after address 3; counters stay 0.
- Word at addr 2 has data bit 5 flipped (nonzero syndrome ≤38) → WB writes corrected word to addr 2; corr_count=1; last_err_addr=2; later re-read shows syndrome 0.
- Force sec_error_location=45 at addr 1 → uncorr_count=1; last_err_addr=1; no mem_we.
- host_req held high on RD entry → host granted every cycle, scrub read deferred; release host_req → scrub read issues next cycle.
- host_req asserted in CHK → host_gnt=0 through CHK/WB/NEXT, granted on return to WAIT; a host read returns corrected data with host_rvalid one cycle after grant.
- Preload corr_count near saturation with 0xFFFF errors → holds at 0xFFFF. Assert reset in WB → no write that cycle, all outputs 0 the next cycle.
